// File: rtl/codificador_pt2262.sv
// PT2262-style pulse-width serial encoder: 8 trinary address trits + 4 data bits + sync per frame.
// Latency: cod_o/busy rise on the same edge that samples te=1 in IDLE; frames repeat back to back.
// Flow control: none; te is level-sensitive and is only looked at in IDLE and at frame end.
//
// Ports:
//   clk        system clock (3 MHz)
//   reset      asynchronous active-low reset
//   A[15:0]    address, trit k = A[2k+1:2k]; 00='0', 11='1', 01/10='F'
//   D[3:0]     data bits, sent D[0] first
//   te         transmit enable (level)
//   cod_o      registered encoded serial output
//   busy       high while a frame is in progress
//   frame_done one-cycle pulse on the edge that ends each frame
module codificador_pt2262 #(
  parameter int T_SHORT    = 8,
  parameter int T_LONG     = 24,
  parameter int T_MID      = 16,
  parameter int SYNC_HIGH  = 4,
  parameter int SYNC_LOW   = 128,
  parameter int MIN_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [3:0]  D,
  input  logic        te,
  output logic        cod_o,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] BIT_HIGH = 3'd1;
  localparam logic [2:0] BIT_LOW  = 3'd2;
  localparam logic [2:0] SYNC_H   = 3'd3;
  localparam logic [2:0] SYNC_L   = 3'd4;

  localparam logic [1:0] SYM_0 = 2'd0;
  localparam logic [1:0] SYM_1 = 2'd1;
  localparam logic [1:0] SYM_F = 2'd2;

  localparam int             FCW   = $clog2(MIN_FRAMES + 1);
  localparam logic [FCW-1:0] MIN_F = FCW'(MIN_FRAMES);

  // Symbol carried by code bit idx of word {D,A}: 0..7 are trits, 8..11 are data bits.
  function automatic logic [1:0] sym_of(input logic [19:0] w, input logic [3:0] idx);
    logic [1:0] t;
    t = w[{1'b0, idx[2:0], 1'b0} +: 2];
    if (idx < 4'd8) begin
      if (t == 2'b00)      sym_of = SYM_0;
      else if (t == 2'b11) sym_of = SYM_1;
      else                 sym_of = SYM_F;
    end else begin
      sym_of = w[{1'b1, 2'b00, idx[1:0]}] ? SYM_1 : SYM_0;
    end
  endfunction

  // Phase counter counts down to zero, so it is loaded with length-1 to make
  // each phase last exactly its nominal number of cycles.
  function automatic logic [7:0] hi_len(input logic [1:0] s);
    case (s)
      SYM_0:   hi_len = 8'(T_SHORT - 1);
      SYM_1:   hi_len = 8'(T_LONG - 1);
      default: hi_len = 8'(T_MID - 1);
    endcase
  endfunction

  function automatic logic [7:0] lo_len(input logic [1:0] s);
    case (s)
      SYM_0:   lo_len = 8'(T_LONG - 1);
      SYM_1:   lo_len = 8'(T_SHORT - 1);
      default: lo_len = 8'(T_MID - 1);
    endcase
  endfunction

  logic [2:0]     state_q, state_d;
  logic [19:0]    shadow_q, shadow_d;
  logic [3:0]     idx_q, idx_d;
  logic [7:0]     ph_q, ph_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           cod_q, cod_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [19:0]    in_word;
  logic           phase_end;
  logic [FCW-1:0] fcnt_inc;

  assign in_word   = {D, A};
  assign phase_end = (ph_q == 8'd0);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    ph_d     = ph_q;
    fcnt_d   = fcnt_q;
    cod_d    = cod_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    fcnt_inc = (fcnt_q < MIN_F) ? fcnt_q + 1'b1 : fcnt_q;

    case (state_q)
      IDLE: begin
        if (te) begin
          shadow_d = in_word;
          idx_d    = 4'd0;
          ph_d     = hi_len(sym_of(in_word, 4'd0));
          fcnt_d   = '0;
          cod_d    = 1'b1;
          busy_d   = 1'b1;
          state_d  = BIT_HIGH;
        end
      end
      BIT_HIGH: begin
        if (phase_end) begin
          ph_d    = lo_len(sym_of(shadow_q, idx_q));
          cod_d   = 1'b0;
          state_d = BIT_LOW;
        end else begin
          ph_d = ph_q - 8'd1;
        end
      end
      BIT_LOW: begin
        if (!phase_end) begin
          ph_d = ph_q - 8'd1;
        end else if (idx_q < 4'd11) begin
          idx_d   = idx_q + 4'd1;
          ph_d    = hi_len(sym_of(shadow_q, idx_q + 4'd1));
          cod_d   = 1'b1;
          state_d = BIT_HIGH;
        end else begin
          ph_d    = 8'(SYNC_HIGH - 1);
          cod_d   = 1'b1;
          state_d = SYNC_H;
        end
      end
      SYNC_H: begin
        if (phase_end) begin
          ph_d    = 8'(SYNC_LOW - 1);
          cod_d   = 1'b0;
          state_d = SYNC_L;
        end else begin
          ph_d = ph_q - 8'd1;
        end
      end
      SYNC_L: begin
        if (!phase_end) begin
          ph_d = ph_q - 8'd1;
        end else begin
          done_d = 1'b1;
          fcnt_d = fcnt_inc;
          // Restart decision uses the already-incremented count so the
          // frame just finished is included.
          if (te || (fcnt_inc < MIN_F)) begin
            shadow_d = in_word;
            idx_d    = 4'd0;
            ph_d     = hi_len(sym_of(in_word, 4'd0));
            cod_d    = 1'b1;
            state_d  = BIT_HIGH;
          end else begin
            idx_d   = 4'd0;
            cod_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        cod_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      ph_q     <= '0;
      fcnt_q   <= '0;
      cod_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      ph_q     <= ph_d;
      fcnt_q   <= fcnt_d;
      cod_q    <= cod_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign cod_o      = cod_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_codificador_pt2262.sv
module tb_codificador_pt2262;

  logic        clk;
  logic        reset;
  logic [15:0] A;
  logic [3:0]  D;
  logic        te;
  logic        cod_o;
  logic        busy;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hi_m[13];
  int lo_m[13];

  codificador_pt2262 dut (
    .clk        (clk),
    .reset      (reset),
    .A          (A),
    .D          (D),
    .te         (te),
    .cod_o      (cod_o),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Measures high/low run lengths of the 13 symbols of one frame, starting at
  // a negedge where cod_o is in its first high cycle. Ends on the negedge of
  // the frame_done cycle. Every loop is bounded.
  task automatic capture_frame();
    for (int b = 0; b < 13; b++) begin
      hi_m[b] = 0;
      lo_m[b] = 0;
      while (cod_o === 1'b1 && hi_m[b] < 300) begin
        hi_m[b]++;
        @(negedge clk);
      end
      while (cod_o === 1'b0 && frame_done !== 1'b1 && lo_m[b] < 300) begin
        lo_m[b]++;
        @(negedge clk);
      end
    end
  endtask

  // One-cycle te pulse; returns at the negedge just after the latching edge.
  task automatic pulse_te();
    @(negedge clk);
    te = 1'b1;
    @(negedge clk);
    te = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s: busy=%b after %0d cycles, required 0", name, busy, n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    te    = 1'b0;
    A     = 16'h0000;
    D     = 4'h0;
    #1;
    total++;
    if ({cod_o, busy, frame_done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_outputs: cod/busy/done=%b required 000", {cod_o, busy, frame_done});
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if ({cod_o, busy, frame_done} !== 3'b000) begin
      bad++;
      $display("FAIL post_reset_idle: cod/busy/done=%b required 000", {cod_o, busy, frame_done});
    end
  endtask

  task automatic test_single_pulse();
    int start;
    A = 16'h0000;
    D = 4'h0;
    @(negedge clk);
    te = 1'b1;
    total++;
    if (cod_o !== 1'b0) begin
      bad++;
      $display("FAIL pre_start_cod: got %b required 0", cod_o);
    end
    @(negedge clk);
    te = 1'b0;
    start = cyc;
    total++;
    if (cod_o !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL start_latency: cod=%b busy=%b required 1 1", cod_o, busy);
    end
    for (int f = 0; f < 4; f++) begin
      capture_frame();
      for (int b = 0; b < 13; b++) begin
        total++;
        if (hi_m[b] !== (b < 12 ? 8 : 4) || lo_m[b] !== (b < 12 ? 24 : 128)) begin
          bad++;
          $display("FAIL zeros_f%0d_b%0d: hi/lo=%0d/%0d required %0d/%0d", f, b, hi_m[b], lo_m[b],
                   (b < 12 ? 8 : 4), (b < 12 ? 24 : 128));
        end
      end
      total++;
      if (frame_done !== 1'b1 || (cyc - start) !== 516 * (f + 1)) begin
        bad++;
        $display("FAIL done_time_f%0d: done=%b at %0d required 1 at %0d", f, frame_done, cyc - start,
                 516 * (f + 1));
      end
      total++;
      if (busy !== (f < 3) || cod_o !== (f < 3)) begin
        bad++;
        $display("FAIL end_state_f%0d: busy=%b cod=%b required %b %b", f, busy, cod_o, f < 3, f < 3);
      end
    end
    @(negedge clk);
    total++;
    if (frame_done !== 1'b0) begin
      bad++;
      $display("FAIL done_one_cycle: got %b required 0", frame_done);
    end
    begin
      int highs;
      highs = 0;
      repeat (60) begin
        if (cod_o !== 1'b0) highs++;
        @(negedge clk);
      end
      total++;
      if (highs !== 0) begin
        bad++;
        $display("FAIL no_fifth_frame: cod high %0d cycles required 0", highs);
      end
    end
  endtask

  task automatic test_back_to_back();
    int start;
    A = 16'hFFFF;
    D = 4'hF;
    @(negedge clk);
    te = 1'b1;
    @(negedge clk);
    start = cyc;
    for (int f = 0; f < 10; f++) begin
      if (f == 9) te = 1'b0;
      capture_frame();
      for (int b = 0; b < 13; b++) begin
        total++;
        if (hi_m[b] !== (b < 12 ? 24 : 4) || lo_m[b] !== (b < 12 ? 8 : 128)) begin
          bad++;
          $display("FAIL ones_f%0d_b%0d: hi/lo=%0d/%0d required %0d/%0d", f, b, hi_m[b], lo_m[b],
                   (b < 12 ? 24 : 4), (b < 12 ? 8 : 128));
        end
      end
      total++;
      if (frame_done !== 1'b1 || (cyc - start) !== 516 * (f + 1) || cod_o !== (f < 9) || busy !== (f < 9)) begin
        bad++;
        $display("FAIL b2b_end_f%0d: done=%b t=%0d cod=%b busy=%b required 1 %0d %b %b", f, frame_done,
                 cyc - start, cod_o, busy, 516 * (f + 1), f < 9, f < 9);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_float_data();
    int eh[13];
    int el[13];
    eh = '{16, 16, 16, 16, 16, 16, 16, 16, 8, 24, 8, 24, 4};
    el = '{16, 16, 16, 16, 16, 16, 16, 16, 24, 8, 24, 8, 128};
    A = 16'hA5A5;
    D = 4'b1010;
    pulse_te();
    capture_frame();
    for (int b = 0; b < 13; b++) begin
      total++;
      if (hi_m[b] !== eh[b] || lo_m[b] !== el[b]) begin
        bad++;
        $display("FAIL float_b%0d: hi/lo=%0d/%0d required %0d/%0d", b, hi_m[b], lo_m[b], eh[b], el[b]);
      end
    end
    wait_idle("float_idle");
  endtask

  task automatic test_mid_frame_change();
    A = 16'h0000;
    D = 4'h0;
    pulse_te();
    fork
      begin
        repeat (99) @(negedge clk);
        A = 16'hFFFF;
      end
    join_none
    capture_frame();
    for (int b = 0; b < 12; b++) begin
      total++;
      if (hi_m[b] !== 8 || lo_m[b] !== 24) begin
        bad++;
        $display("FAIL change_f1_b%0d: hi/lo=%0d/%0d required 8/24", b, hi_m[b], lo_m[b]);
      end
    end
    capture_frame();
    for (int b = 0; b < 12; b++) begin
      total++;
      if (hi_m[b] !== (b < 8 ? 24 : 8) || lo_m[b] !== (b < 8 ? 8 : 24)) begin
        bad++;
        $display("FAIL change_f2_b%0d: hi/lo=%0d/%0d required %0d/%0d", b, hi_m[b], lo_m[b],
                 (b < 8 ? 24 : 8), (b < 8 ? 8 : 24));
      end
    end
    wait_idle("change_idle");
    A = 16'h0000;
  endtask

  task automatic test_reset_mid_frame();
    int highs;
    A = 16'h0000;
    D = 4'h0;
    pulse_te();
    @(negedge clk);
    @(negedge clk);
    total++;
    if (cod_o !== 1'b1) begin
      bad++;
      $display("FAIL mid_high_before_reset: cod=%b required 1", cod_o);
    end
    #3 reset = 1'b0;
    #1;
    total++;
    if (cod_o !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: cod=%b busy=%b required 0 0", cod_o, busy);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    highs = 0;
    repeat (1000) begin
      @(negedge clk);
      if (cod_o !== 1'b0 || busy !== 1'b0) highs++;
    end
    total++;
    if (highs !== 0) begin
      bad++;
      $display("FAIL no_resume: active %0d cycles required 0", highs);
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_back_to_back();
    test_float_data();
    test_mid_frame_change();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
